// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Used by the iterative encryption core and its combinational round.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } aes_state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rcon for rounds 1..10; any other round yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
// The final round skips MixColumns.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic [7:0]   rcon_i,
    input  logic         final_i,
    output logic [127:0] state_o,
    output logic [127:0] round_key_o
);

    logic [7:0]   sub_bytes [16];
    logic [7:0]   key_sub [4];
    logic [31:0]  rot_word;
    logic [7:0]   shifted [16];
    logic [127:0] shifted_flat;
    logic [127:0] mixed;
    logic [31:0]  temp;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   a0, a1, a2, a3;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (
            .in_i  (state_i[127-8*i -: 8]),
            .out_o (sub_bytes[i])
        );
    end

    // RotWord of the last key word.
    assign rot_word = {round_key_i[23:0], round_key_i[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (
            .in_i  (rot_word[31-8*i -: 8]),
            .out_o (key_sub[i])
        );
    end

    always_comb begin
        temp        = {key_sub[0] ^ rcon_i, key_sub[1], key_sub[2], key_sub[3]};
        w0          = round_key_i[127:96] ^ temp;
        w1          = round_key_i[95:64] ^ w0;
        w2          = round_key_i[63:32] ^ w1;
        w3          = round_key_i[31:0] ^ w2;
        round_key_o = {w0, w1, w2, w3};
    end

    always_comb begin
        shifted_flat = '0;
        mixed        = '0;
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        // Byte index is 4*col + row; row r takes its byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[4*c+r] = sub_bytes[4*((c+r)%4)+r];
                shifted_flat[127-8*(4*c+r) -: 8] = shifted[4*c+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = shifted[4*c];
            a1 = shifted[4*c+1];
            a2 = shifted[4*c+2];
            a3 = shifted[4*c+3];
            mixed[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        state_o = (final_i ? shifted_flat : mixed) ^ round_key_o;
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// The inverse is x^254, built from repeated squaring so no 256-entry table is needed.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    logic [7:0] inv;
    logic [7:0] pw;

    always_comb begin
        // x^2 * x^4 * ... * x^128 = x^254; zero maps to zero.
        inv = 8'h01;
        pw  = in_i;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Accept, ten round cycles, then hold the result until out_ready.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic         final_round;

    assign final_round = (round_q == 4'(NR));

    aes_enc_round u_round (
        .state_i     (state_q),
        .round_key_i (round_key_q),
        .rcon_i      (rcon(round_q)),
        .final_i     (final_round),
        .state_o     (rnd_state),
        .round_key_o (rnd_key)
    );

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_key_d = round_key_q;
        round_d     = round_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        ciphertext  = '0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d     = plaintext ^ key;
                    round_key_d = key;
                    round_d     = 4'd1;
                    fsm_d       = StRound;
                end
            end
            StRound: begin
                state_d     = rnd_state;
                round_key_d = rnd_key;
                if (final_round) begin
                    fsm_d = StDone;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            StDone: begin
                out_valid  = 1'b1;
                ciphertext = state_q;
                if (out_ready) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            round_key_q <= '0;
            round_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_q     <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using the FIPS-197 example vectors.
// Latency is counted as edges after the accept edge; 10 of them makes 11 counting the accept edge.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] p, input logic [127:0] k);
        in_valid  = 1'b1;
        plaintext = p;
        key       = k;
        tick();
        in_valid  = 1'b0;
    endtask

    // Edges after the accept edge until out_valid, bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        tick();
        tick();
        total++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            bad++;
            $display("FAIL reset_flags: busy/in_ready/out_valid got %b want 010",
                     {busy, in_ready, out_valid});
        end
        total++;
        if (ciphertext !== '0) begin
            bad++;
            $display("FAIL reset_ct: got %h want 0", ciphertext);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({busy, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release: busy/in_ready got %b want 01", {busy, in_ready});
        end
    endtask

    task automatic test_vector1();
        int n;
        start_block(P1, K1);
        total++;
        if ({busy, in_ready, out_valid} !== 3'b100 || ciphertext !== '0) begin
            bad++;
            $display("FAIL v1_round_flags: busy/in_ready/out_valid %b ct %h want 100 ct 0",
                     {busy, in_ready, out_valid}, ciphertext);
        end
        wait_done(n);
        total++;
        if (n !== 10) begin
            bad++;
            $display("FAIL v1_latency: got %0d want 10", n);
        end
        total++;
        if (ciphertext !== C1) begin
            bad++;
            $display("FAIL v1_ct: got %h want %h", ciphertext, C1);
        end
        total++;
        if ({busy, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL v1_done_flags: busy/in_ready got %b want 10", {busy, in_ready});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({busy, in_ready, out_valid} !== 3'b010 || ciphertext !== '0) begin
            bad++;
            $display("FAIL v1_release: busy/in_ready/out_valid %b ct %h want 010 ct 0",
                     {busy, in_ready, out_valid}, ciphertext);
        end
    endtask

    task automatic test_stall();
        int n;
        start_block(P2, K2);
        wait_done(n);
        total++;
        if (n !== 10 || ciphertext !== C2) begin
            bad++;
            $display("FAIL v2_ct: latency %0d ct %h want 10 ct %h", n, ciphertext, C2);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ciphertext !== C2) begin
                bad++;
                $display("FAIL stall_hold[%0d]: out_valid %b in_ready %b ct %h want 1 0 %h",
                         i, out_valid, in_ready, ciphertext, C2);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL stall_release: in_ready/out_valid got %b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_ignore_inputs();
        int n;
        start_block(P1, K1);
        tick();
        tick();
        in_valid = 1'b1; plaintext = P2; key = K2; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ignore_ready: in_ready %b out_valid %b want 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        wait_done(n);
        total++;
        if (n !== 4 || ciphertext !== C1) begin
            bad++;
            $display("FAIL ignore_ct: remaining %0d ct %h want 4 ct %h", n, ciphertext, C1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        start_block(P1, K1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, in_ready, out_valid} !== 3'b010 || ciphertext !== '0) begin
            bad++;
            $display("FAIL abort_flags: busy/in_ready/out_valid %b ct %h want 010 ct 0",
                     {busy, in_ready, out_valid}, ciphertext);
        end
        start_block(P1, K1);
        wait_done(n);
        total++;
        if (n !== 10 || ciphertext !== C1) begin
            bad++;
            $display("FAIL abort_restart: latency %0d ct %h want 10 ct %h", n, ciphertext, C1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k;
        int n;
        int lat1;
        logic [127:0] ct1;
        k = 0; lat1 = -1; ct1 = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; plaintext = P1; key = K1;
        tick();
        plaintext = P2; key = K2;
        while (k < 40) begin
            tick();
            k++;
            if (out_valid && lat1 < 0) begin
                lat1 = k;
                ct1  = ciphertext;
            end
            if (in_ready) break;
        end
        total++;
        if (lat1 !== 10 || ct1 !== C1) begin
            bad++;
            $display("FAIL b2b_first: latency %0d ct %h want 10 ct %h", lat1, ct1, C1);
        end
        total++;
        if (k + 1 !== 12) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 12", k + 1);
        end
        tick();
        in_valid = 1'b0;
        wait_done(n);
        total++;
        if (n !== 10 || ciphertext !== C2) begin
            bad++;
            $display("FAIL b2b_second: latency %0d ct %h want 10 ct %h", n, ciphertext, C2);
        end
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: in_ready got %b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_vector1();
        test_stall();
        test_ignore_inputs();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: in_valid  input  1  plaintext and key presented.
REQ-005 Port: in_ready  output  1  core can accept a block.
REQ-006 Port: plaintext  input  128  state bytes column-major; bits [127:120] = row0/col0, [119:112] = row1/col0, ..., [7:0] = row3/col3.
REQ-007 Port: key  input  128  AES-128 cipher key, same byte order as plaintext.
REQ-008 Port: out_valid  output  1  ciphertext holds a finished result.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: ciphertext  output  128  encrypted block, same byte order.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FIPS-197 AES-128 forward cipher: initial AddRoundKey, then 9 rounds of SubBytes, ShiftRows, MixColumns and AddRoundKey, then a final round with MixColumns omitted.
REQ-013 ShiftRows SHALL rotate row r left by r columns: out row1/col0 = in row1/col1, out row2/col0 = in row2/col2, out row3/col0 = in row3/col3.
REQ-014 MixColumns SHALL use GF(2^8) polynomial 0x11B with xtime.
REQ-015 Round keys SHALL be expanded on the fly, one per round, with Rcon sequence 01,02,04,08,10,20,40,80,1B,36; no 176-byte key store.
REQ-016 FSM states SHALL be IDLE, ROUND and DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, state <= plaintext^key, round_key <= key, round counter <= 1, next state ROUND.
REQ-018 ROUND: one round per clock; at counter==10 apply the final round, then go to DONE; otherwise increment the counter.
REQ-019 Latency SHALL be exactly 11 clocks from the accept edge to the edge that raises out_valid.
REQ-020 DONE: out_valid=1, ciphertext stable; on out_ready go to IDLE and clear out_valid on the same edge.
REQ-021 in_ready SHALL be 0 in ROUND and DONE; in_valid there SHALL be ignored and SHALL NOT corrupt the in-flight block.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 ciphertext SHALL read zero outside DONE.
REQ-024 Back-to-back throughput SHALL be one block per 12 clocks minimum (accept, 10 rounds, one DONE/handshake cycle).

Reset
REQ-025 rst SHALL force IDLE, round counter 0, state and round_key registers 0, out_valid 0, busy 0 and in_ready 1 after the reset edge.
REQ-026 rst asserted mid-operation (ROUND or DONE) SHALL abort the block with no result emitted; rst has priority over every handshake.

Structure
REQ-027 Shared package aes_pkg SHALL hold: NR=10, FSM state encoding, Rcon table, xtime function.
REQ-028 One sub-module aes_enc_round SHALL be the combinational round: state and round key in; final-round flag in; next state and next round key out.
REQ-029 aes_enc_round SHALL instantiate the team's existing S-box module: 16 instances for the state, 4 for the key schedule.

Verification
REQ-030 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 clocks after accept.
REQ-031 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-032 out_ready held low 20 clocks after completion -> out_valid and ciphertext stay stable and in_ready stays 0; releasing out_ready -> IDLE next clock.
REQ-033 in_valid toggled with a different plaintext during ROUND -> result still equals the first block's expected ciphertext.
REQ-034 rst pulsed at round 5 -> next clock busy=0, in_ready=1, out_valid=0; a fresh REQ-030 block then completes correctly.
REQ-035 Two blocks back-to-back with out_ready tied high -> both correct, accepts 12 clocks apart.
